// File: rtl/mem_wb_multi.sv
// rtl/mem_wb_multi.sv - MEM/WB pipeline register with multi-lane write collision resolution
// Optional performance counters are enabled by defining MEM_WB_PERF_EN.
module mem_wb_multi #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter int LANES  = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     mem_valid,
   input  logic [LANES*ADDR_W-1:0]  mem_waddr,
   input  logic [LANES-1:0]         mem_we,
   input  logic [LANES*DATA_W-1:0]  mem_wdata,
   input  logic                     mem_whilo,
   input  logic [DATA_W-1:0]        mem_hi,
   input  logic [DATA_W-1:0]        mem_lo,
   input  logic [5:0]               stall,
   input  logic                     flush,
   output logic                     wb_valid,
   output logic [LANES*ADDR_W-1:0]  wb_waddr,
   output logic [LANES-1:0]         wb_we,
   output logic [LANES*DATA_W-1:0]  wb_wdata,
   output logic                     wb_whilo,
   output logic [DATA_W-1:0]        wb_hi,
   output logic [DATA_W-1:0]        wb_lo,
   output logic                     wb_conflict
`ifdef MEM_WB_PERF_EN
   ,
   output logic [31:0]              perf_retired,
   output logic [31:0]              perf_bubbles
`endif
);

   logic             load_empty;
   logic             capture;
   logic [LANES-1:0] we_in;
   logic [LANES-1:0] shadowed;
   logic [LANES-1:0] we_keep;
   logic             unused_stall;

   assign unused_stall = ^stall[3:0];

   // Flush dominates every stall combination; a bubble only when MEM stalls and WB does not.
   assign load_empty = flush || (stall[4] && !stall[5]);
   assign capture    = !stall[4];

   always_comb begin
      we_in    = mem_valid ? mem_we : '0;
      shadowed = '0;
      for (int i = 0; i < LANES; i++) begin
         for (int j = i + 1; j < LANES; j++) begin
            if (we_in[i] && we_in[j] &&
                mem_waddr[i*ADDR_W +: ADDR_W] == mem_waddr[j*ADDR_W +: ADDR_W]) begin
               shadowed[i] = 1'b1;
            end
         end
      end
      we_keep = we_in & ~shadowed;
      // Register 0 is hardwired, so writes to it are dropped after collision detection.
      for (int i = 0; i < LANES; i++) begin
         if (mem_waddr[i*ADDR_W +: ADDR_W] == '0) begin
            we_keep[i] = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst || load_empty) begin
         wb_valid    <= 1'b0;
         wb_waddr    <= '0;
         wb_we       <= '0;
         wb_wdata    <= '0;
         wb_whilo    <= 1'b0;
         wb_hi       <= '0;
         wb_lo       <= '0;
         wb_conflict <= 1'b0;
      end else if (capture) begin
         wb_valid    <= mem_valid;
         wb_waddr    <= mem_waddr;
         wb_we       <= we_keep;
         wb_wdata    <= mem_wdata;
         wb_whilo    <= mem_valid && mem_whilo;
         wb_hi       <= mem_hi;
         wb_lo       <= mem_lo;
         wb_conflict <= |shadowed;
      end
   end

`ifdef MEM_WB_PERF_EN
   always_ff @(posedge clk) begin
      if (!rst) begin
         perf_retired <= '0;
         perf_bubbles <= '0;
      end else if (load_empty) begin
         perf_bubbles <= perf_bubbles + 32'd1;
      end else if (capture && mem_valid) begin
         perf_retired <= perf_retired + 32'd1;
      end
   end
`endif

endmodule
